blinkt_frame_gen: RTL and testbench

//  Upstream frame builder for the Blinkt APA102 LED bar. Holds per-LED colour/brightness registers

---
 rtl/blinkt_pkg.sv | 16 +
 rtl/blinkt_led_regs.sv | 41 ++++
 rtl/blinkt_frame_gen.sv | 145 ++++++++++++++
 tb/tb_blinkt_frame_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinkt_pkg.sv
// Shared types and helpers for the Blinkt APA102 frame generator: FSM states, frame marker words
// and the LED word packer.
package blinkt_pkg;

    typedef enum logic [1:0] {IDLE, START, LEDS, END} state_t;

    localparam logic [31:0] START_FRAME = 32'h0000_0000;
    localparam logic [31:0] END_FRAME   = 32'hFFFF_FFFF;
    localparam logic [2:0]  LED_HDR     = 3'b111;

    // led = {bright[4:0], blue, green, red}
    function automatic logic [31:0] pack_led(input logic [28:0] led);
        return {LED_HDR, led};
    endfunction

endpackage

// File: rtl/blinkt_led_regs.sv
// Per-LED staging registers (bus writes, any time) and a shadow copy captured in one cycle on snap;
// frame words are read from the shadow combinationally by index, so writes never disturb a frame in flight.
module blinkt_led_regs #(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [28:0]   wr_data,
    input  logic          snap,
    input  logic [AW-1:0] rd_idx,
    output logic [28:0]   rd_data
);

    logic [28:0] staging [NUM_LEDS];
    logic [28:0] shadow  [NUM_LEDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                staging[i] <= '0;
                shadow[i]  <= '0;
            end
        end else begin
            if (wr_en && (int'(wr_addr) < NUM_LEDS))
                staging[wr_addr] <= wr_data;
            if (snap)
                shadow <= staging;
        end
    end

    // Out-of-range indices read as zero; only reachable for non-power-of-two bars.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_LEDS)
            rd_data = shadow[rd_idx];
    end

endmodule

// File: rtl/blinkt_frame_gen.sv
// APA102 frame builder: update -> start word valid next cycle, then LED and end words, each held until ready.
// Optional periodic refresh under BLINKT_AUTO_REFRESH_EN; updates during a frame queue one follow-on frame.
module blinkt_frame_gen
    import blinkt_pkg::*;
#(
    parameter int  NUM_LEDS       = 8,
    parameter int  END_WORDS      = 1,
    parameter int  REFRESH_CYCLES = 1000000,
    localparam int AW             = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          axis_aclk,
    input  logic          axis_aresetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          update,
    output logic          busy,
    output logic [31:0]   m_axis_data,
    output logic          m_axis_valid,
    input  logic          m_axis_ready
);

    localparam int CW = $clog2(NUM_LEDS + END_WORDS + 1);

    if (NUM_LEDS < 1 || NUM_LEDS > 64 || END_WORDS < (NUM_LEDS + 63) / 64 || REFRESH_CYCLES < 1) begin : g_bad_cfg
        $error("blinkt_frame_gen: illegal parameter combination");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          req;
    logic          refresh;
    logic          hs;
    logic          snap;
    logic          last_led;
    logic          last_end;
    logic [AW-1:0] rd_idx;
    logic [28:0]   rd_data;
    logic          unused_wr_hi;

    assign unused_wr_hi = ^wr_data[31:29];

`ifdef BLINKT_AUTO_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [RW-1:0] ref_cnt;

    assign refresh = (ref_cnt == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn)
            ref_cnt <= '0;
        else
            ref_cnt <= refresh ? '0 : ref_cnt + 1'b1;
    end
`else
    assign refresh = 1'b0;
`endif

    assign req      = update | refresh;
    assign hs       = m_axis_valid & m_axis_ready;
    assign last_led = (cnt == CW'(NUM_LEDS - 1));
    assign last_end = (cnt == CW'(END_WORDS - 1));
    // Shadow is captured on the edge that enters START, so LED 0 is ready for the START handshake.
    assign snap     = ((state == IDLE) && (req || pending)) ||
                      ((state == END) && hs && last_end && pending);
    assign rd_idx   = (state == LEDS) ? AW'(cnt + 1'b1) : '0;

    blinkt_led_regs #(
        .NUM_LEDS (NUM_LEDS),
        .AW       (AW)
    ) u_led_regs (
        .clk     (axis_aclk),
        .rst_n   (axis_aresetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data[28:0]),
        .snap    (snap),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state        <= IDLE;
            cnt          <= '0;
            pending      <= 1'b0;
            busy         <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
        end else begin
            if (req && (state != IDLE))
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (req || pending) begin
                        state        <= START;
                        pending      <= 1'b0;
                        busy         <= 1'b1;
                        m_axis_valid <= 1'b1;
                        m_axis_data  <= START_FRAME;
                    end
                end
                START: begin
                    if (hs) begin
                        state       <= LEDS;
                        cnt         <= '0;
                        m_axis_data <= pack_led(rd_data);
                    end
                end
                LEDS: begin
                    if (hs) begin
                        if (last_led) begin
                            state       <= END;
                            cnt         <= '0;
                            m_axis_data <= END_FRAME;
                        end else begin
                            cnt         <= cnt + 1'b1;
                            m_axis_data <= pack_led(rd_data);
                        end
                    end
                end
                END: begin
                    if (hs) begin
                        cnt <= '0;
                        if (!last_end) begin
                            cnt <= cnt + 1'b1;
                        end else if (pending) begin
                            // Back-to-back frame: any update arriving now merges into this one.
                            state       <= START;
                            pending     <= 1'b0;
                            m_axis_data <= START_FRAME;
                        end else begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            m_axis_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blinkt_frame_gen.sv
// Directed bench for blinkt_frame_gen (8 LEDs, 1 end word) with an expected-word queue checked on every handshake.
module tb_blinkt_frame_gen;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        update;
    logic        busy;
    logic [31:0] data;
    logic        valid;
    logic        m_axis_ready = 1'b0;

    int          tests = 0;
    int          fails = 0;
    int          ready_mode = 0;
    bit          sb_en = 1'b1;
    logic [31:0] exp_q[$];
    logic [28:0] model [N];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always #5 clk = ~clk;

    blinkt_frame_gen #(
        .NUM_LEDS       (N),
        .END_WORDS      (1),
        .REFRESH_CYCLES (200)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .update       (update),
        .busy         (busy),
        .m_axis_data  (data),
        .m_axis_valid (valid),
        .m_axis_ready (m_axis_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = 1'($urandom_range(0, 1));
            default: m_axis_ready = 1'b0;
        endcase
    end

    // Scoreboard and AXIS hold-stable monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid), 32'd1);
                check("hold_data", data, prev_data);
            end
            if (valid && m_axis_ready && sb_en) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_extra: observed word %h expected none", data);
                end
                if (exp_q.size() != 0)
                    check("word", data, exp_q.pop_front());
            end
            prev_stall <= valid && !m_axis_ready;
            prev_data  <= data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame;
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < N; i++)
            exp_q.push_back({3'b111, model[i]});
        exp_q.push_back(32'hFFFF_FFFF);
    endtask

    task automatic pulse_update;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic write_led(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = d;
        tick();
        wr_en    = 1'b0;
        model[a] = d[28:0];
    endtask

    // Wait for all expected words; valid and busy must stay high while any remain.
    task automatic drain(input string tag);
        int n = 0;
        int gaps = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
            if (exp_q.size() != 0 && (busy !== 1'b1 || valid !== 1'b1))
                gaps++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_gap"}, 32'(gaps), 32'd0);
        tick();
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_valid_end"}, 32'(valid), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        update  = 1'b0;
        for (int i = 0; i < N; i++)
            model[i] = '0;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", data, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

`ifdef BLINKT_AUTO_REFRESH_EN
        begin : refresh_blk
            int   rises;
            int   first;
            int   second;
            logic pv;
            rises = 0; first = -1; second = -1; pv = 1'b0;
            sb_en = 1'b0;
            ready_mode = 0;
            for (int c = 0; c < 450; c++) begin
                @(negedge clk);
                if (valid && !pv) begin
                    rises++;
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
                pv = valid;
            end
            check("t6_frames", 32'(rises), 32'd2);
            check("t6_period", 32'(second - first), 32'd200);
        end
`else
        // 1: all-zero LEDs, ready tied high, one-cycle start latency
        ready_mode = 0;
        tick();
        push_frame();
        pulse_update();
        check("t1_latency_valid", 32'(valid), 32'd1);
        check("t1_latency_busy", 32'(busy), 32'd1);
        check("t1_first_data", data, 32'h0000_0000);
        drain("t1");

        // 2: random backpressure, LED3 colour
        ready_mode = 1;
        write_led(3, 32'h1F00_00FF);
        push_frame();
        pulse_update();
        drain("t2");

        // 3: write during a frame only shows up in the next frame
        push_frame();
        pulse_update();
        write_led(0, 32'h0111_2233);
        drain("t3a");
        push_frame();
        pulse_update();
        drain("t3b");

        // 4: three updates during a frame merge into one back-to-back frame
        push_frame();
        pulse_update();
        tick();
        push_frame();
        pulse_update();
        tick();
        pulse_update();
        tick();
        pulse_update();
        drain("t4");
        begin : t4_idle
            int seen;
            seen = 0;
            repeat (30) begin
                tick();
                if (valid || busy) seen++;
            end
            check("t4_no_third", 32'(seen), 32'd0);
        end

        // 5: asynchronous reset mid-LEDS with ready low
        sb_en = 1'b0;
        ready_mode = 0;
        pulse_update();
        tick();
        tick();
        ready_mode = 2;
        tick();
        tick();
        check("t5_pre_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_data", data, 32'd0);
        exp_q.delete();
        for (int i = 0; i < N; i++)
            model[i] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sb_en = 1'b1;
        ready_mode = 1;
        push_frame();
        pulse_update();
        drain("t5");

        // 6: no auto-refresh in the default build
        ready_mode = 0;
        begin : t6_idle
            int seen;
            seen = 0;
            repeat (300) begin
                tick();
                if (valid || busy) seen++;
            end
            check("t6_no_frames", 32'(seen), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
